// File: rtl/div_sequencer_if.sv
// div_sequencer_if: EX-stage handshake between the pipeline and the divide sequencer
interface div_sequencer_if #(
    parameter int CNT_W = 6
);
    logic             i_valid;
    logic [5:0]       i_funct;
    logic             i_div_zero;
    logic             o_div_load;
    logic             o_div_step;
    logic             o_hilo_we;
    logic             o_busy;
    logic             o_stall;
    logic [1:0]       o_hilo_sel;
    logic             o_dz_flag;
    logic [CNT_W-1:0] o_step_cnt;

    modport master (
        output i_valid, i_funct, i_div_zero,
        input  o_div_load, o_div_step, o_hilo_we, o_busy, o_stall, o_hilo_sel, o_dz_flag, o_step_cnt
    );

    modport slave (
        input  i_valid, i_funct, i_div_zero,
        output o_div_load, o_div_step, o_hilo_we, o_busy, o_stall, o_hilo_sel, o_dz_flag, o_step_cnt
    );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIVU control FSM with HI/LO interlock
module div_sequencer #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input logic            clk,
    input logic            rst,
    div_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dz;
    logic [1:0]       w_next;
    logic             w_busy;
    logic             w_divu;
    logic             w_mfhi;
    logic             w_mflo;
    logic             w_accept;
    logic             w_last;

    assign w_busy   = r_state != S_IDLE;
    assign w_divu   = bus.i_valid && bus.i_funct == F_DIVU;
    assign w_mfhi   = bus.i_valid && bus.i_funct == F_MFHI;
    assign w_mflo   = bus.i_valid && bus.i_funct == F_MFLO;
    assign w_accept = w_divu && !w_busy;
    assign w_last   = r_cnt == CNT_W'(DIV_CYCLES - 1);

    // Reset forces the interlock open, so a pending HI/LO consumer or DIVU never stalls that cycle
    assign bus.o_stall    = !rst && w_busy && (w_divu || w_mfhi || w_mflo);
    assign bus.o_hilo_sel = (w_mfhi && !bus.o_stall) ? 2'b01 :
                            (w_mflo && !bus.o_stall) ? 2'b10 : 2'b00;
    assign bus.o_div_load = r_state == S_LOAD;
    assign bus.o_div_step = r_state == S_RUN;
    assign bus.o_hilo_we  = r_state == S_WRITE;
    assign bus.o_busy     = w_busy;
    assign bus.o_dz_flag  = r_dz;
    assign bus.o_step_cnt = r_cnt;

    // Next-state decode: a zero divisor skips RUN and writes straight away
    always_comb begin
        w_next = (r_state == S_IDLE) ? (w_accept ? S_LOAD : S_IDLE) :
                 (r_state == S_LOAD) ? (bus.i_div_zero ? S_WRITE : S_RUN) :
                 (r_state == S_RUN)  ? (w_last ? S_WRITE : S_RUN) : S_IDLE;
    end

    // State, step counter and sticky divide-by-zero flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_LOAD) ? '0 :
                       (r_state == S_RUN)  ? r_cnt + 1'b1 : r_cnt;
            r_dz    <= w_accept ? 1'b0 :
                       (r_state == S_LOAD && bus.i_div_zero) ? 1'b1 : r_dz;
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard bench for div_sequencer with directed vectors
module tb_div_sequencer;
    localparam logic [5:0] F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_ADD  = 6'b100000;

    typedef struct {int c; int dz; int st;} we_t;
    typedef struct {int c; int s;} sel_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    int   steps = 0;
    int   t0;
    int   q_load[$];
    we_t  q_we[$];
    sel_t q_sel[$];

    div_sequencer_if #(.CNT_W(6)) bus ();

    div_sequencer #(.DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, int a, int e);
        nchk++;
        if (a != e) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
        end
    endfunction

    function automatic void unexpected(string n);
        nchk++;
        nerr++;
        $display("FAIL %s: got event expected none (cycle %0d)", n, cyc);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [5:0] f);
        bus.i_valid = v;
        bus.i_funct = f;
    endtask

    task automatic push_op(int base, int dz, int st, int we_off);
        q_load.push_back(base + 1);
        q_we.push_back('{c: base + we_off, dz: dz, st: st});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && bus.o_busy; i++) tick();
        chk("busy_bound", int'(bus.o_busy), 0);
    endtask

    // Monitor: pop the expected event whenever the DUT presents one
    always @(negedge clk) begin
        if (bus.o_div_step === 1'b1) steps++;
        if (bus.o_div_load === 1'b1) begin
            steps = 0;
            if (q_load.size() == 0) unexpected("div_load");
            else chk("load_cycle", cyc, q_load.pop_front());
        end
        if (bus.o_hilo_we === 1'b1) begin
            if (q_we.size() == 0) unexpected("hilo_we");
            else begin
                we_t e;
                e = q_we.pop_front();
                chk("we_cycle", cyc, e.c);
                chk("we_dz", int'(bus.o_dz_flag), e.dz);
                chk("we_steps", steps, e.st);
            end
        end
        if (bus.o_hilo_sel !== 2'b00 && !$isunknown(bus.o_hilo_sel)) begin
            if (q_sel.size() == 0) unexpected("hilo_sel");
            else begin
                sel_t s;
                s = q_sel.pop_front();
                chk("sel_cycle", cyc, s.c);
                chk("sel_value", int'(bus.o_hilo_sel), s.s);
            end
        end
    end

    initial begin
        drive(1'b0, 6'd0);
        bus.i_div_zero = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_cnt", int'(bus.o_step_cnt), 0);
        chk("rst_dz", int'(bus.o_dz_flag), 0);
        chk("rst_stall", int'(bus.o_stall), 0);
        tick();

        // Single DIVU: load at 1, 32 steps, write at 34, idle at 35
        t0 = cyc;
        drive(1'b1, F_DIVU);
        push_op(t0, 0, 32, 34);
        #1;
        chk("accept_stall", int'(bus.o_stall), 0);
        tick();
        drive(1'b0, 6'd0);
        wait_idle();
        chk("idle_cycle", cyc, t0 + 35);
        chk("cnt_hold", int'(bus.o_step_cnt), 32);

        // ALU op runs through; MFLO interlocks until the fresh LO is ready
        t0 = cyc;
        drive(1'b1, F_DIVU);
        push_op(t0, 0, 32, 34);
        tick();
        drive(1'b0, 6'd0);
        repeat (9) tick();
        drive(1'b1, F_ADD);
        #1;
        chk("add_stall", int'(bus.o_stall), 0);
        tick();
        drive(1'b0, 6'd0);
        tick();
        drive(1'b1, F_MFLO);
        for (int c = 12; c <= 34; c++) begin
            #1;
            chk("mflo_stall", int'(bus.o_stall), 1);
            tick();
        end
        q_sel.push_back('{c: t0 + 35, s: 2});
        #1;
        chk("mflo_release", int'(bus.o_stall), 0);
        tick();
        drive(1'b0, 6'd0);

        // Divide by zero: write two cycles after accept, no steps, sticky flag
        t0 = cyc;
        drive(1'b1, F_DIVU);
        push_op(t0, 1, 0, 2);
        tick();
        drive(1'b0, 6'd0);
        bus.i_div_zero = 1'b1;
        tick();
        bus.i_div_zero = 1'b0;
        #1;
        chk("dz_set", int'(bus.o_dz_flag), 1);
        tick();
        chk("dz_busy", int'(bus.o_busy), 0);
        chk("dz_hold", int'(bus.o_dz_flag), 1);
        t0 = cyc;
        drive(1'b1, F_DIVU);
        push_op(t0, 0, 32, 34);
        tick();
        drive(1'b0, 6'd0);
        chk("dz_clear", int'(bus.o_dz_flag), 0);
        wait_idle();

        // Back-to-back DIVU held valid: second accepted at 35, written at 69
        t0 = cyc;
        drive(1'b1, F_DIVU);
        push_op(t0, 0, 32, 34);
        tick();
        for (int c = 1; c <= 34; c++) begin
            #1;
            chk("b2b_stall", int'(bus.o_stall), 1);
            tick();
        end
        push_op(t0 + 35, 0, 32, 34);
        #1;
        chk("b2b_accept", int'(bus.o_stall), 0);
        tick();
        drive(1'b0, 6'd0);
        wait_idle();
        chk("b2b_idle", cyc, t0 + 70);

        // Reset mid-RUN aborts without a write; MFLO under reset is not stalled
        t0 = cyc;
        drive(1'b1, F_DIVU);
        q_load.push_back(t0 + 1);
        tick();
        drive(1'b0, 6'd0);
        repeat (19) tick();
        chk("run_cnt", int'(bus.o_step_cnt), 18);
        rst = 1'b1;
        drive(1'b1, F_MFLO);
        q_sel.push_back('{c: t0 + 20, s: 2});
        #1;
        chk("rst_mflo_stall", int'(bus.o_stall), 0);
        tick();
        rst = 1'b0;
        drive(1'b0, 6'd0);
        chk("abort_busy", int'(bus.o_busy), 0);
        chk("abort_cnt", int'(bus.o_step_cnt), 0);
        chk("abort_step", int'(bus.o_div_step), 0);
        repeat (3) tick();
        t0 = cyc;
        drive(1'b1, F_DIVU);
        push_op(t0, 0, 32, 34);
        tick();
        drive(1'b0, 6'd0);
        wait_idle();
        chk("post_rst_idle", cyc, t0 + 35);

        // MFHI in IDLE with no divide since reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, F_MFHI);
        q_sel.push_back('{c: cyc, s: 1});
        #1;
        chk("mfhi_stall", int'(bus.o_stall), 0);
        chk("mfhi_sel", int'(bus.o_hilo_sel), 1);
        tick();
        drive(1'b0, 6'd0);

        repeat (3) tick();
        chk("q_load_empty", q_load.size(), 0);
        chk("q_we_empty", q_we.size(), 0);
        chk("q_sel_empty", q_sel.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
